multicycle_control: RTL and testbench

//  Multicycle control FSM that drives the DECODE stage and its neighbours.

---
 rtl/ctrl_pkg.sv | 45 ++++
 rtl/multicycle_control_if.sv | 35 +++
 rtl/ctrl_opdecode.sv | 80 ++++++++
 rtl/multicycle_control.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the CHARIS multicycle controller: state encoding,
// opcode constants and ALU operation codes.
package ctrl_pkg;

  localparam int MEM_WAIT_MAX_DEF = 15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DEC,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_BRANCH
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_NANDI = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_NAND = 4'b0101;

  // Function codes the ALU actually implements (low nibble of the func field).
  function automatic logic func_legal(input logic [3:0] f);
    return f inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA};
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle controller and the datapath.
interface multicycle_control_if;

  logic [5:0] Instr_op;
  logic [5:0] Instr_func;
  logic       ALU_zero;
  logic       MEM_Ack;

  logic       IR_LdEn;
  logic       PC_LdEn;
  logic       PC_sel;
  logic       RF_WrEn;
  logic       RF_WrData_sel;
  logic       RF_B_sel;
  logic       ALU_Bin_sel;
  logic [3:0] ALU_func;
  logic       MEM_RdEn;
  logic       MEM_WrEn;
  logic       ByteOp;
  logic       Illegal;
  logic       Mem_Err;

  modport master (
    input  Instr_op, Instr_func, ALU_zero, MEM_Ack,
    output IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel,
           ALU_Bin_sel, ALU_func, MEM_RdEn, MEM_WrEn, ByteOp, Illegal, Mem_Err
  );

  modport slave (
    output Instr_op, Instr_func, ALU_zero, MEM_Ack,
    input  IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel,
           ALU_Bin_sel, ALU_func, MEM_RdEn, MEM_WrEn, ByteOp, Illegal, Mem_Err
  );

endinterface

// File: rtl/ctrl_opdecode.sv
// Combinational classifier for the instruction held in IR: instruction class,
// branch flavour, access width and the ALU operation for the execute step.
module ctrl_opdecode
  import ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic       is_r,
  output logic       is_imm,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_illegal,
  output logic       bad_func,
  output logic       is_byte,
  output logic       br_uncond,
  output logic       br_eq,
  output logic       br_ne,
  output logic [3:0] alu_code
);

  // Only the low nibble selects the ALU operation.
  logic unused_func_hi;
  assign unused_func_hi = ^func[5:4];

  always_comb begin
    is_r       = 1'b0;
    is_imm     = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_illegal = 1'b0;
    bad_func   = 1'b0;
    is_byte    = 1'b0;
    br_uncond  = 1'b0;
    br_eq      = 1'b0;
    br_ne      = 1'b0;
    alu_code   = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        is_r     = 1'b1;
        alu_code = func[3:0];
        bad_func = !func_legal(func[3:0]);
      end
      OP_LI, OP_LUI, OP_ADDI: is_imm = 1'b1;
      OP_NANDI: begin
        is_imm   = 1'b1;
        alu_code = ALU_NAND;
      end
      OP_ORI: begin
        is_imm   = 1'b1;
        alu_code = ALU_OR;
      end
      OP_LB: begin
        is_load = 1'b1;
        is_byte = 1'b1;
      end
      OP_LW: is_load = 1'b1;
      OP_SB: begin
        is_store = 1'b1;
        is_byte  = 1'b1;
      end
      OP_SW: is_store = 1'b1;
      OP_B: begin
        is_branch = 1'b1;
        br_uncond = 1'b1;
      end
      OP_BEQ: begin
        is_branch = 1'b1;
        br_eq     = 1'b1;
      end
      OP_BNE: begin
        is_branch = 1'b1;
        br_ne     = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer for CHARIS instructions: fetch, decode, execute,
// memory and write-back strobes for the datapath, with a memory-ack timeout.
//
// state      | meaning
// S_IDLE     | out of reset, all strobes low
// S_FETCH    | load IR
// S_DEC      | classify opcode, read RF; unknown opcode skips to next word
// S_EXEC_R   | register ALU op (func field); unknown func skips
// S_EXEC_I   | immediate ALU op
// S_MEM_ADDR | effective address = rs + Immed
// S_MEM_RD   | read request held until MEM_Ack or timeout
// S_MEM_WR   | write request held until MEM_Ack or timeout
// S_WB_ALU   | write ALU result, PC+4
// S_WB_MEM   | write memory data, PC+4
// S_BRANCH   | compare via sub, select PC target
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF
) (
  input logic                  Clk,
  input logic                  Rst_n,
  multicycle_control_if.master bus
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MEM_WAIT_MAX);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;

  logic       is_r, is_imm, is_load, is_store, is_branch, is_illegal;
  logic       bad_func, is_byte, br_uncond, br_eq, br_ne;
  logic [3:0] alu_code;

  ctrl_opdecode u_opdecode (
    .op         (bus.Instr_op),
    .func       (bus.Instr_func),
    .is_r       (is_r),
    .is_imm     (is_imm),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_branch  (is_branch),
    .is_illegal (is_illegal),
    .bad_func   (bad_func),
    .is_byte    (is_byte),
    .br_uncond  (br_uncond),
    .br_eq      (br_eq),
    .br_ne      (br_ne),
    .alu_code   (alu_code)
  );

  logic mem_state, mem_ack, mem_timeout;
  assign mem_state   = (state == S_MEM_RD) || (state == S_MEM_WR);
  assign mem_ack     = mem_state && bus.MEM_Ack;
  // An ack arriving on the limit cycle still completes the access.
  assign mem_timeout = mem_state && !bus.MEM_Ack && (wait_cnt == WAIT_LIM);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wait_cnt <= '0;
    end else if (!mem_state) begin
      wait_cnt <= '0;
    end else if (!bus.MEM_Ack && (wait_cnt != WAIT_LIM)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_DEC;
      S_DEC: begin
        if (is_r)                     state_nxt = S_EXEC_R;
        else if (is_imm)              state_nxt = S_EXEC_I;
        else if (is_load || is_store) state_nxt = S_MEM_ADDR;
        else if (is_branch)           state_nxt = S_BRANCH;
        else                          state_nxt = S_FETCH;
      end
      S_EXEC_R:   state_nxt = bad_func ? S_FETCH : S_WB_ALU;
      S_EXEC_I:   state_nxt = S_WB_ALU;
      S_MEM_ADDR: state_nxt = is_load ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ack)          state_nxt = S_WB_MEM;
        else if (mem_timeout) state_nxt = S_FETCH;
      end
      S_MEM_WR: begin
        if (mem_ack || mem_timeout) state_nxt = S_FETCH;
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH: state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.IR_LdEn       = 1'b0;
    bus.PC_LdEn       = 1'b0;
    bus.PC_sel        = 1'b0;
    bus.RF_WrEn       = 1'b0;
    bus.RF_WrData_sel = 1'b0;
    bus.RF_B_sel      = 1'b0;
    bus.ALU_Bin_sel   = 1'b0;
    bus.ALU_func      = ALU_ADD;
    bus.MEM_RdEn      = 1'b0;
    bus.MEM_WrEn      = 1'b0;
    bus.ByteOp        = 1'b0;
    bus.Illegal       = 1'b0;
    bus.Mem_Err       = 1'b0;
    case (state)
      S_FETCH: bus.IR_LdEn = 1'b1;
      S_DEC: begin
        bus.RF_B_sel = is_store || is_branch;
        bus.Illegal  = is_illegal;
        bus.PC_LdEn  = is_illegal;
      end
      S_EXEC_R: begin
        bus.ALU_func = alu_code;
        bus.Illegal  = bad_func;
        bus.PC_LdEn  = bad_func;
      end
      S_EXEC_I: begin
        bus.ALU_Bin_sel = 1'b1;
        bus.ALU_func    = alu_code;
      end
      S_MEM_ADDR: begin
        bus.ALU_Bin_sel = 1'b1;
        bus.RF_B_sel    = is_store;
        bus.ByteOp      = is_byte;
      end
      S_MEM_RD: begin
        bus.MEM_RdEn = 1'b1;
        bus.ByteOp   = is_byte;
        bus.Mem_Err  = mem_timeout;
        bus.PC_LdEn  = mem_timeout;
      end
      S_MEM_WR: begin
        bus.MEM_WrEn = 1'b1;
        bus.RF_B_sel = 1'b1;
        bus.ByteOp   = is_byte;
        bus.Mem_Err  = mem_timeout;
        bus.PC_LdEn  = mem_ack || mem_timeout;
      end
      S_WB_ALU: begin
        bus.RF_WrEn = 1'b1;
        bus.PC_LdEn = 1'b1;
      end
      S_WB_MEM: begin
        bus.RF_WrEn       = 1'b1;
        bus.PC_LdEn       = 1'b1;
        bus.RF_WrData_sel = 1'b1;
        bus.ByteOp        = is_byte;
      end
      S_BRANCH: begin
        bus.ALU_func = ALU_SUB;
        bus.RF_B_sel = 1'b1;
        bus.PC_LdEn  = 1'b1;
        bus.PC_sel   = br_uncond || (br_eq && bus.ALU_zero) || (br_ne && !bus.ALU_zero);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle output vectors for each
// instruction class, memory wait/timeout corners and async reset.
module tb_multicycle_control;

  logic Clk;
  logic Rst_n;
  int   checks;
  int   errors;

  multicycle_control_if bus();

  multicycle_control #(.MEM_WAIT_MAX(15)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Output vector layout, MSB first; bit 0 is always zero.
  localparam logic [16:0] O_IR   = 17'd1 << 16;
  localparam logic [16:0] O_PCL  = 17'd1 << 15;
  localparam logic [16:0] O_PCS  = 17'd1 << 14;
  localparam logic [16:0] O_RFW  = 17'd1 << 13;
  localparam logic [16:0] O_WDS  = 17'd1 << 12;
  localparam logic [16:0] O_BSEL = 17'd1 << 11;
  localparam logic [16:0] O_BIN  = 17'd1 << 10;
  localparam logic [16:0] O_RD   = 17'd1 << 5;
  localparam logic [16:0] O_WR   = 17'd1 << 4;
  localparam logic [16:0] O_BYTE = 17'd1 << 3;
  localparam logic [16:0] O_ILL  = 17'd1 << 2;
  localparam logic [16:0] O_MERR = 17'd1 << 1;

  logic [16:0] obs;
  assign obs = {bus.IR_LdEn, bus.PC_LdEn, bus.PC_sel, bus.RF_WrEn, bus.RF_WrData_sel,
                bus.RF_B_sel, bus.ALU_Bin_sel, bus.ALU_func, bus.MEM_RdEn,
                bus.MEM_WrEn, bus.ByteOp, bus.Illegal, bus.Mem_Err, 1'b0};

  function automatic logic [16:0] fa(input logic [3:0] f);
    return {7'b0, f, 6'b0};
  endfunction

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  // Every scenario task starts just after the negedge sample of a FETCH cycle
  // and ends at the negedge sample of the following FETCH cycle.
  task automatic test_reset();
    Rst_n = 1'b0;
    bus.MEM_Ack = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (obs !== 17'd0) begin
      errors++;
      $display("FAIL reset_outs got %h expected %h", obs, 17'd0);
    end
    next_cycle();
    Rst_n = 1'b1;
    bus.MEM_Ack = 1'b0;
    @(negedge Clk);
    checks++;
    if (obs !== 17'd0) begin
      errors++;
      $display("FAIL reset_idle got %h expected %h", obs, 17'd0);
    end
    next_cycle();
    @(negedge Clk);
    checks++;
    if (obs !== O_IR) begin
      errors++;
      $display("FAIL reset_fetch got %h expected %h", obs, O_IR);
    end
  endtask

  task automatic test_r_type(input logic [5:0] func, input logic [3:0] alu, input logic legal);
    logic [16:0] exp[$];
    bus.Instr_op   = 6'b100000;
    bus.Instr_func = func;
    exp.push_back(17'd0);
    if (legal) begin
      exp.push_back(fa(alu));
      exp.push_back(O_RFW | O_PCL);
    end else begin
      exp.push_back(fa(alu) | O_ILL | O_PCL);
    end
    exp.push_back(O_IR);
    for (int i = 0; i < exp.size(); i++) begin
      next_cycle();
      @(negedge Clk);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL r_type_%b[%0d] got %h expected %h", func, i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_imm(input logic [5:0] op, input logic [3:0] alu);
    logic [16:0] exp[$];
    bus.Instr_op = op;
    exp.push_back(17'd0);
    exp.push_back(O_BIN | fa(alu));
    exp.push_back(O_RFW | O_PCL);
    exp.push_back(O_IR);
    for (int i = 0; i < exp.size(); i++) begin
      next_cycle();
      @(negedge Clk);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL imm_%b[%0d] got %h expected %h", op, i, obs, exp[i]);
      end
    end
  endtask

  // Ack arrives after 'waits' no-ack read cycles; a stray ack in MEM_ADDR must be ignored.
  task automatic test_load(input logic [5:0] op, input logic byte_op, input int waits);
    logic [16:0] exp[$];
    logic [16:0] b;
    int          ack_i;
    b = byte_op ? O_BYTE : 17'd0;
    ack_i = 2 + waits;
    bus.Instr_op = op;
    exp.push_back(17'd0);
    exp.push_back(O_BIN | b);
    for (int k = 0; k <= waits; k++) exp.push_back(O_RD | b);
    exp.push_back(O_RFW | O_PCL | O_WDS | b);
    exp.push_back(O_IR);
    for (int i = 0; i < exp.size(); i++) begin
      next_cycle();
      bus.MEM_Ack = (i == 1) || (i == ack_i);
      @(negedge Clk);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL load_%b[%0d] got %h expected %h", op, i, obs, exp[i]);
      end
    end
    bus.MEM_Ack = 1'b0;
  endtask

  // timeout=1: no ack at all, caller passes waits=15 (the limit).
  task automatic test_store(input logic [5:0] op, input logic byte_op, input int waits,
                            input logic timeout);
    logic [16:0] exp[$];
    logic [16:0] b;
    int          ack_i;
    b = byte_op ? O_BYTE : 17'd0;
    ack_i = timeout ? -1 : 2 + waits;
    bus.Instr_op = op;
    exp.push_back(O_BSEL);
    exp.push_back(O_BIN | O_BSEL | b);
    for (int k = 0; k < waits; k++) exp.push_back(O_WR | O_BSEL | b);
    exp.push_back(O_WR | O_BSEL | b | O_PCL | (timeout ? O_MERR : 17'd0));
    exp.push_back(O_IR);
    for (int i = 0; i < exp.size(); i++) begin
      next_cycle();
      bus.MEM_Ack = (i == ack_i);
      @(negedge Clk);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL store_%b_to%0d[%0d] got %h expected %h", op, timeout, i, obs, exp[i]);
      end
    end
    bus.MEM_Ack = 1'b0;
  endtask

  task automatic test_branch(input logic [5:0] op, input logic zero, input logic taken);
    logic [16:0] exp[$];
    bus.Instr_op = op;
    bus.ALU_zero = zero;
    exp.push_back(O_BSEL);
    exp.push_back(O_BSEL | O_PCL | fa(4'b0001) | (taken ? O_PCS : 17'd0));
    exp.push_back(O_IR);
    for (int i = 0; i < exp.size(); i++) begin
      next_cycle();
      @(negedge Clk);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL branch_%b_z%0d[%0d] got %h expected %h", op, zero, i, obs, exp[i]);
      end
    end
    bus.ALU_zero = 1'b0;
  endtask

  task automatic test_illegal_op(input logic [5:0] op);
    logic [16:0] exp[$];
    bus.Instr_op = op;
    exp.push_back(O_ILL | O_PCL);
    exp.push_back(O_IR);
    for (int i = 0; i < exp.size(); i++) begin
      next_cycle();
      @(negedge Clk);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL illegal_%b[%0d] got %h expected %h", op, i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [16:0] exp[$];
    bus.Instr_op = 6'b001111;
    exp.push_back(17'd0);
    exp.push_back(O_BIN);
    exp.push_back(O_RD);
    exp.push_back(O_RD);
    for (int i = 0; i < exp.size(); i++) begin
      next_cycle();
      @(negedge Clk);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL mid_rst_pre[%0d] got %h expected %h", i, obs, exp[i]);
      end
    end
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 17'd0) begin
      errors++;
      $display("FAIL mid_rst_async got %h expected %h", obs, 17'd0);
    end
    bus.MEM_Ack = 1'b1;
    next_cycle();
    checks++;
    if (obs !== 17'd0) begin
      errors++;
      $display("FAIL mid_rst_hold got %h expected %h", obs, 17'd0);
    end
    Rst_n = 1'b1;
    bus.MEM_Ack = 1'b0;
    @(negedge Clk);
    checks++;
    if (obs !== 17'd0) begin
      errors++;
      $display("FAIL mid_rst_idle got %h expected %h", obs, 17'd0);
    end
    next_cycle();
    @(negedge Clk);
    checks++;
    if (obs !== O_IR) begin
      errors++;
      $display("FAIL mid_rst_fetch got %h expected %h", obs, O_IR);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Rst_n = 1'b0;
    bus.Instr_op = 6'b0;
    bus.Instr_func = 6'b0;
    bus.ALU_zero = 1'b0;
    bus.MEM_Ack = 1'b0;

    test_reset();

    test_r_type(6'b110000, 4'h0, 1'b1);
    test_r_type(6'b110001, 4'h1, 1'b1);
    test_r_type(6'b111010, 4'hA, 1'b1);
    test_r_type(6'b110110, 4'h6, 1'b0);
    test_r_type(6'b111111, 4'hF, 1'b0);

    test_imm(6'b110000, 4'b0000);
    test_imm(6'b110010, 4'b0101);
    test_imm(6'b110011, 4'b0011);
    test_imm(6'b111001, 4'b0000);

    // lw: 3 no-ack cycles, MEM_RdEn over 4 cycles, 8 cycles FETCH to FETCH
    test_load(6'b001111, 1'b0, 3);
    test_load(6'b000011, 1'b1, 0);

    test_store(6'b011111, 1'b0, 2, 1'b0);
    test_store(6'b011111, 1'b0, 15, 1'b1);
    test_store(6'b000111, 1'b1, 15, 1'b0);

    test_branch(6'b000000, 1'b1, 1'b1);
    test_branch(6'b000000, 1'b0, 1'b0);
    test_branch(6'b000001, 1'b0, 1'b1);
    test_branch(6'b000001, 1'b1, 1'b0);
    test_branch(6'b111111, 1'b0, 1'b1);
    test_branch(6'b111111, 1'b1, 1'b1);

    test_illegal_op(6'b101010);
    test_illegal_op(6'b010101);

    test_reset_mid_access();
    test_r_type(6'b110000, 4'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
